axi_lite_rd_wr_arbiter: RTL

Shares one AXI-lite slave (memory port) between two masters.
- Master 0 is the instruction fetch unit, read-only.
- Master 1 is the load/store unit, read and write.
- Only one transaction is outstanding at a time.
- Grant is held from address handshake through response handshake.
- Ties go round-robin, so a continuously requesting IFU cannot starve the LSU.

---
 rtl/axi_lite_rd_wr_arbiter_if.sv | 46 ++++
 rtl/axi_lite_rd_wr_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_rd_wr_arbiter_if.sv
// AXI-lite bus bundle shared by both upstream masters and the downstream
// memory port. The master modport is the side that issues addresses and
// data; the slave modport is the side that answers.
interface axi_lite_rd_wr_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 64
);
    // read address channel
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    // read data channel
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    // write address channel
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    // write data channel
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    // write response channel
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output araddr, arvalid, input  arready,
        input  rdata, rresp, rvalid, output rready,
        output awaddr, awvalid, input  awready,
        output wdata, wstrb, wvalid, input  wready,
        input  bresp, bvalid, output bready
    );

    modport slave (
        input  araddr, arvalid, output arready,
        output rdata, rresp, rvalid, input  rready,
        input  awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input  bready
    );
endinterface

// File: rtl/axi_lite_rd_wr_arbiter.sv
// Two-master AXI-lite arbiter in front of a single memory port.
// m0 is the read-only instruction fetch port, m1 the read/write load/store
// port. One transaction is in flight at a time; the owner keeps the grant
// from its address handshake until its response handshake. Simultaneous
// requests alternate between the masters so neither can starve the other.
module axi_lite_rd_wr_arbiter #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    axi_lite_rd_wr_arbiter_if.slave   m0,
    axi_lite_rd_wr_arbiter_if.slave   m1,
    axi_lite_rd_wr_arbiter_if.master  s,
    output logic [1:0]                grant
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] M0_AR = 3'd1;
    localparam logic [2:0] M0_R  = 3'd2;
    localparam logic [2:0] M1_AR = 3'd3;
    localparam logic [2:0] M1_R  = 3'd4;
    localparam logic [2:0] M1_WR = 3'd5;
    localparam logic [2:0] M1_B  = 3'd6;

    logic [2:0]    state;
    // index of the master served most recently; 1 lets m0 win the first tie
    logic          last;
    logic          aw_done;
    logic          w_done;

    logic          req0;
    logic          req1w;
    logic          req1r;
    logic          req1;

    logic          ar_fire;
    logic          r_fire;
    logic          aw_fire;
    logic          w_fire;
    logic          b_fire;
    logic          aw_seen;
    logic          w_seen;

    logic [AW-1:0] araddr_sel;
    logic [DW-1:0] rdata_pass;

    // m0 never writes; its write-side inputs are intentionally ignored
    logic          unused_m0_wr;

    assign req0  = m0.arvalid;
    assign req1w = m1.awvalid & m1.wvalid;
    assign req1r = m1.arvalid;
    assign req1  = req1w | req1r;

    // handshakes seen on the memory side; the valids are already gated by state
    assign ar_fire = s.arvalid & s.arready;
    assign r_fire  = s.rvalid  & s.rready;
    assign aw_fire = s.awvalid & s.awready;
    assign w_fire  = s.wvalid  & s.wready;
    assign b_fire  = s.bvalid  & s.bready;

    // a channel counts as complete if it finished earlier or finishes now
    assign aw_seen = aw_done | aw_fire;
    assign w_seen  = w_done  | w_fire;

    assign rdata_pass = s.rdata;

    assign unused_m0_wr = ^{m0.awaddr, m0.awvalid, m0.wdata, m0.wstrb,
                            m0.wvalid, m0.bready};

    // Arbitration and transaction sequencing; the grant decision is registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        state <= M0_AR;
                    end else if (req1) begin
                        // a pending store goes ahead of a pending load
                        state <= req1w ? M1_WR : M1_AR;
                    end
                end
                M0_AR: begin
                    if (ar_fire) begin
                        state <= M0_R;
                    end
                end
                M0_R: begin
                    if (r_fire) begin
                        state <= IDLE;
                        last  <= 1'b0;
                    end
                end
                M1_AR: begin
                    if (ar_fire) begin
                        state <= M1_R;
                    end
                end
                M1_R: begin
                    if (r_fire) begin
                        state <= IDLE;
                        last  <= 1'b1;
                    end
                end
                M1_WR: begin
                    if (aw_seen && w_seen) begin
                        state   <= M1_B;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end else begin
                        aw_done <= aw_seen;
                        w_done  <= w_seen;
                    end
                end
                M1_B: begin
                    if (b_fire) begin
                        state <= IDLE;
                        last  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Read address source for the memory port follows the owning master
    always_comb begin
        araddr_sel = '0;
        if (state == M0_AR) begin
            araddr_sel = m0.araddr;
        end else if (state == M1_AR) begin
            araddr_sel = m1.araddr;
        end
    end

    // Channel routing: only the owner's channel of the current phase is
    // connected; every other valid and ready is forced low
    always_comb begin
        s.araddr   = araddr_sel;
        s.arvalid  = 1'b0;
        s.rready   = 1'b0;
        s.awaddr   = m1.awaddr;
        s.awvalid  = 1'b0;
        s.wdata    = m1.wdata;
        s.wstrb    = m1.wstrb;
        s.wvalid   = 1'b0;
        s.bready   = 1'b0;

        m0.arready = 1'b0;
        m0.rdata   = rdata_pass;
        m0.rresp   = s.rresp;
        m0.rvalid  = 1'b0;
        m0.awready = 1'b0;
        m0.wready  = 1'b0;
        m0.bresp   = '0;
        m0.bvalid  = 1'b0;

        m1.arready = 1'b0;
        m1.rdata   = rdata_pass;
        m1.rresp   = s.rresp;
        m1.rvalid  = 1'b0;
        m1.awready = 1'b0;
        m1.wready  = 1'b0;
        m1.bresp   = s.bresp;
        m1.bvalid  = 1'b0;

        grant      = 2'b00;

        case (state)
            M0_AR: begin
                grant      = 2'b01;
                s.arvalid  = m0.arvalid;
                m0.arready = s.arready;
            end
            M0_R: begin
                grant      = 2'b01;
                m0.rvalid  = s.rvalid;
                s.rready   = m0.rready;
            end
            M1_AR: begin
                grant      = 2'b10;
                s.arvalid  = m1.arvalid;
                m1.arready = s.arready;
            end
            M1_R: begin
                grant      = 2'b10;
                m1.rvalid  = s.rvalid;
                s.rready   = m1.rready;
            end
            M1_WR: begin
                // a channel that already completed is masked so it is never
                // presented to the memory port twice
                grant      = 2'b10;
                s.awvalid  = m1.awvalid & ~aw_done;
                m1.awready = s.awready  & ~aw_done;
                s.wvalid   = m1.wvalid  & ~w_done;
                m1.wready  = s.wready   & ~w_done;
            end
            M1_B: begin
                grant      = 2'b10;
                m1.bvalid  = s.bvalid;
                s.bready   = m1.bready;
            end
            default: begin
                grant      = 2'b00;
            end
        endcase
    end

endmodule
